// File: rtl/traffic_phase_ctrl.sv
// Actuated two-way intersection controller: NS/EW greens with min/max timing,
// yellow, all-red clearance, pedestrian walk phase and emergency preemption.
module traffic_phase_ctrl #(
    parameter int TMR_W     = 8,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    input  logic       preempt,
    output logic [1:0] ns,
    output logic [1:0] ew,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_ALLRED    = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_WALK      = 3'd5
    } state_e;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_GREEN  = 2'b01;
    localparam logic [1:0] LT_YELLOW = 2'b10;

    // Last count value of each timed state: expiry is a tick seen at this value.
    localparam logic [TMR_W-1:0] ALLRED_LAST = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] YELLOW_LAST = TMR_W'(YELLOW_T - 1);
    localparam logic [TMR_W-1:0] WALK_LAST   = TMR_W'(WALK_T - 1);
    localparam logic [TMR_W-1:0] GMIN_LAST   = TMR_W'(GREEN_MIN - 1);
    localparam logic [TMR_W-1:0] GMAX_LAST   = TMR_W'(GREEN_MAX - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               next_dir_q, next_dir_d;
    logic               ped_pending_q, ped_pending_d;

    logic               own_req;
    logic               opp_req;
    logic               green_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ALLRED;
            timer_q       <= '0;
            next_dir_q    <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Demand seen by whichever direction currently holds green.
    always_comb begin
        own_req = (state_q == ST_EW_GREEN) ? ew_req : ns_req;
        opp_req = (state_q == ST_EW_GREEN) ? ns_req : ew_req;
        green_exit = (timer_q >= GMIN_LAST) && (opp_req || ped_pending_q) &&
                     (!own_req || (timer_q >= GMAX_LAST));
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        next_dir_d    = next_dir_q;
        ped_pending_d = ped_pending_q | (ped_req & (state_q != ST_WALK));

        case (state_q)
            ST_ALLRED: begin
                if (preempt) begin
                    timer_d = '0;
                end else if (tick) begin
                    if (timer_q == ALLRED_LAST) begin
                        if (ped_pending_q)   state_d = ST_WALK;
                        else if (next_dir_q) state_d = ST_EW_GREEN;
                        else                 state_d = ST_NS_GREEN;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
            end

            ST_NS_GREEN, ST_EW_GREEN: begin
                if (preempt || (tick && green_exit)) begin
                    state_d = (state_q == ST_NS_GREEN) ? ST_NS_YELLOW : ST_EW_YELLOW;
                end else if (tick && (timer_q != GMAX_LAST)) begin
                    // Saturate so a resting green still honours max-green on new demand.
                    timer_d = timer_q + TMR_ONE;
                end
            end

            ST_NS_YELLOW, ST_EW_YELLOW: begin
                if (tick) begin
                    if (timer_q == YELLOW_LAST) begin
                        state_d    = ST_ALLRED;
                        next_dir_d = (state_q == ST_NS_YELLOW);
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
            end

            ST_WALK: begin
                if (preempt) begin
                    state_d = ST_ALLRED;
                end else if (tick) begin
                    if (timer_q == WALK_LAST) state_d = ST_ALLRED;
                    else                      timer_d = timer_q + TMR_ONE;
                end
            end

            default: state_d = ST_ALLRED;
        endcase

        // Every state entry restarts the timer; entering WALK consumes the request.
        if (state_d != state_q) begin
            timer_d = '0;
            if (state_d == ST_WALK) ped_pending_d = 1'b0;
        end
    end

    always_comb begin
        ns    = LT_RED;
        ew    = LT_RED;
        walk  = 1'b0;
        phase = state_q;
        case (state_q)
            ST_NS_GREEN:  ns   = LT_GREEN;
            ST_NS_YELLOW: ns   = LT_YELLOW;
            ST_EW_GREEN:  ew   = LT_GREEN;
            ST_EW_YELLOW: ew   = LT_YELLOW;
            ST_WALK:      walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl: a tick-counting phase model feeds a
// scoreboard queue; a monitor compares DUT outputs once per cycle.
module tb_traffic_phase_ctrl;

    localparam int GMIN = 10;
    localparam int GMAX = 30;
    localparam int YT   = 3;
    localparam int AT   = 2;
    localparam int WT   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       preempt = 1'b0;
    logic [1:0] ns, ew;
    logic       walk;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    // Reference state: phase number, ticks spent in it, service order, ped latch.
    int m_ph;
    int m_cnt;
    bit m_dir;
    bit m_ped;

    traffic_phase_ctrl #(
        .TMR_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YELLOW_T(YT), .ALLRED_T(AT), .WALK_T(WT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ns_req(ns_req), .ew_req(ew_req),
        .ped_req(ped_req), .preempt(preempt), .ns(ns), .ew(ew), .walk(walk), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outputs_of(int ph);
        logic [1:0] e_ns;
        logic [1:0] e_ew;
        logic [2:0] e_ph;
        e_ns = (ph == 1) ? 2'b01 : (ph == 2) ? 2'b10 : 2'b00;
        e_ew = (ph == 3) ? 2'b01 : (ph == 4) ? 2'b10 : 2'b00;
        e_ph = 3'(ph);
        return {e_ph, e_ns, e_ew, (ph == 5)};
    endfunction

    function automatic void model_reset();
        m_ph  = 0;
        m_cnt = 0;
        m_dir = 1'b0;
        m_ped = 1'b0;
    endfunction

    function automatic void model_step(bit tk, bit nr, bit er, bit pr, bit pe);
        int  nxt;
        bit  mine, other;
        nxt = m_ph;
        case (m_ph)
            0: if (!pe && tk && (m_cnt + 1 == AT))
                   nxt = m_ped ? 5 : (m_dir ? 3 : 1);
            1, 3: begin
                mine  = (m_ph == 1) ? nr : er;
                other = (m_ph == 1) ? er : nr;
                if (pe) nxt = m_ph + 1;
                else if (tk && (m_cnt + 1 >= GMIN) && (other || m_ped) &&
                         (!mine || (m_cnt + 1 >= GMAX)))
                    nxt = m_ph + 1;
            end
            2, 4: if (tk && (m_cnt + 1 == YT)) begin
                nxt   = 0;
                m_dir = (m_ph == 2);
            end
            default: if (pe || (tk && (m_cnt + 1 == WT))) nxt = 0;
        endcase
        if (pr && m_ph != 5) m_ped = 1'b1;
        if (nxt == 5 && m_ph != 5) m_ped = 1'b0;
        if (nxt != m_ph)           m_cnt = 0;
        else if (m_ph == 0 && pe)  m_cnt = 0;
        else if (tk)               m_cnt = m_cnt + 1;
        m_ph = nxt;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got phase/ns/ew/walk=%h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected output word per clock edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {phase, ns, ew, walk}, e);
            end
        end
    end

    initial begin
        int tick_mode;
        bit use_pre, quiet;
        int n_resets;
        n_resets = 0;
        #1 rst_n = 1'b0;
        #1 check("reset_init", {phase, ns, ew, walk}, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_held", {phase, ns, ew, walk}, 8'h00);
        rst_n = 1'b1;
        model_reset();

        for (int seg = 0; seg < 60; seg++) begin
            tick_mode = $urandom_range(0, 3);
            use_pre   = ($urandom_range(0, 3) == 0);
            quiet     = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < 300; c++) begin
                // Asynchronous reset landing mid-green, between clock edges.
                if (n_resets < 8 && (m_ph == 1 || m_ph == 3) && $urandom_range(0, 149) == 0) begin
                    n_resets++;
                    #2 rst_n = 1'b0;
                    #1 check("async_reset", {phase, ns, ew, walk}, 8'h00);
                    model_reset();
                    @(negedge clk);
                    check("reset_hold", {phase, ns, ew, walk}, 8'h00);
                    rst_n = 1'b1;
                end
                case (tick_mode)
                    0:       tick = 1'b1;
                    1:       tick = ($urandom_range(0, 1) == 0);
                    2:       tick = ($urandom_range(0, 3) == 0);
                    default: tick = ($urandom_range(0, 7) == 0);
                endcase
                if (quiet) begin
                    ns_req = 1'b0;
                    ew_req = 1'b0;
                end else begin
                    if ($urandom_range(0, 39) == 0) ns_req = ~ns_req;
                    if ($urandom_range(0, 39) == 0) ew_req = ~ew_req;
                end
                ped_req = ($urandom_range(0, 59) == 0);
                // Bias toward a button press on the edge that enters WALK.
                if (m_ph == 0 && m_ped && m_cnt == AT - 1 && $urandom_range(0, 1) == 0)
                    ped_req = 1'b1;
                if (!use_pre) preempt = 1'b0;
                else if ($urandom_range(0, 79) == 0) preempt = ~preempt;
                model_step(tick, ns_req, ew_req, ped_req, preempt);
                exp_q.push_back(outputs_of(m_ph));
                @(negedge clk);
            end
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Actuated two-way intersection controller: sequences North-South and East-West signal heads plus a pedestrian walk phase from vehicle/pedestrian demand, using tick-based timers for minimum/maximum green, yellow, all-red clearance and walk. It sits above the light-drive logic and emits the team-standard 2-bit light codes directly. A preempt input forces all-red for emergency vehicles.

## Interface
- `TMR_W`, 8: phase timer width. All durations must be in 1..2^TMR_W-1.
- `GREEN_MIN`, 10: minimum green, in ticks.
- `GREEN_MAX`, 30: maximum green under contention, in ticks. Must satisfy GREEN_MAX ≥ GREEN_MIN.
- `YELLOW_T`, 3: yellow duration, in ticks.
- `ALLRED_T`, 2: all-red clearance, in ticks.
- `WALK_T`, 8: pedestrian walk duration, in ticks.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle timebase strobe, synchronous to clk.
- `ns_req`  in  1  NS vehicle demand (level).
- `ew_req`  in  1  EW vehicle demand (level).
- `ped_req`  in  1  pedestrian button (pulse or level).
- `preempt`  in  1  emergency preemption (level).
- `ns`  out  2  NS light: 00 red, 01 green, 10 yellow; 11 never driven.
- `ew`  out  2  EW light, same encoding.
- `walk`  out  1  pedestrian walk indication.
- `phase`  out  3  current state: 0 ALLRED, 1 NS_GREEN, 2 NS_YELLOW, 3 EW_GREEN, 4 EW_YELLOW, 5 WALK.

## Operation
- Registered state: `state`, `timer[TMR_W-1:0]`, `next_dir` (0 = NS, 1 = EW), `ped_pending`.
- Timer clears to 0 on every state entry. It increments on each `tick` while in the state. "Expires" means tick=1 and timer==DUR-1, so every timed state lasts exactly DUR ticks.
- ALLRED: ns=ew=00.
  - On expiry of ALLRED_T: go to WALK if ped_pending, else NS_GREEN (next_dir=0) or EW_GREEN (next_dir=1).
- X_GREEN (X = NS or EW; opp = the other direction): light X=01.
  - Competing demand = opp_req | ped_pending.
  - On a tick with timer ≥ GREEN_MIN-1 and competing demand, go to X_YELLOW if X_req=0 or timer ≥ GREEN_MAX-1.
  - With no competing demand, rest in green indefinitely. Timer saturates at GREEN_MAX-1.
- X_YELLOW: light X=10. On expiry of YELLOW_T go to ALLRED and set next_dir = opp.
- WALK: ns=ew=00, walk=1. On expiry of WALK_T go to ALLRED; next_dir is unchanged.
- ped_pending:
  - Set on any cycle with ped_req=1, except while in WALK.
  - Cleared on the edge that enters WALK. Clear wins if ped_req is high on that same edge.
- preempt=1:
  - From X_GREEN, go to X_YELLOW on the next clk edge, with no tick needed.
  - From WALK, go to ALLRED on the next edge.
  - X_YELLOW continues its normal timing.
  - ALLRED holds with timer forced to 0.
  - No green or WALK is entered while preempt=1.
  - After release, ALLRED counts a full ALLRED_T before exiting.
- Outputs are decoded combinationally from the registered state only (Moore). No input reaches an output without passing through a register.

## Timing
- Reset (rst_n=0, asynchronous, effective immediately): state=ALLRED, timer=0, next_dir=0, ped_pending=0. Therefore ns=00, ew=00, walk=0, phase=0.
- Reset asserted mid-phase drops every output to red / walk=0 immediately, without waiting for a clk edge.
- All transitions occur on a rising clk edge. Outputs reflect the new state in that same cycle.
- Input-to-transition latency:
  - preempt exit from green: 1 cycle.
  - Demand-driven exit: at the first qualifying tick edge.
- Simultaneous ns_req and ew_req during ALLRED: next_dir decides the order (strict alternation).
- A tick on the entry edge is not counted.
- tick held high continuously is legal: one count per cycle.

## Test plan
1. Reset and initial service: rst_n low during NS_GREEN → ns=ew=00, walk=0, phase=0 immediately. Release with no requests → NS_GREEN after exactly 2 ticks, then rests there for 100 ticks.
2. Minimum green: in NS_GREEN, ns_req=0, ew_req pulsed high at timer=3 and held → NS_YELLOW at tick 10, ALLRED after 3 ticks, EW_GREEN after 2 more, ew=01.
3. Maximum green: ns_req=1 and ew_req=1 held → NS_GREEN lasts exactly 30 ticks, followed by the NS_YELLOW → ALLRED → EW_GREEN sequence.
4. Pedestrian: 1-cycle ped_req during EW_GREEN (ew_req=1, timer ≥ 9) → EW_YELLOW(3) → ALLRED(2) → WALK (8 ticks, walk=1) → ALLRED(2) → NS_GREEN. ped_req pulsed during WALK causes no second WALK.
5. Preempt: preempt=1 in NS_GREEN at timer=2 → NS_YELLOW on the next edge (no tick), 3 ticks later ALLRED, held 20 ticks. Release → EW_GREEN exactly 2 ticks later.
6. Coincidence: ped_req high on the edge entering WALK → ped_pending=0 after the edge, and exactly one WALK phase occurs.
